// File: rtl/seq_restoring_div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the counter-width helper.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, used to size the iteration counter so it can hold WIDTH.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_restoring_div_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
interface seq_restoring_div_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_div_full_sub_nb.sv
// N-bit ripple subtractor built from one-bit full_sub cells; borrow-in is 0.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module full_sub_nb #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow_out
);
    logic [N:0] borrow;

    assign borrow[0]  = 1'b0;
    assign borrow_out = borrow[N];

    for (genvar i = 0; i < N; i++) begin : g_cell
        full_sub u_cell (
            .a   (a[i]),
            .b   (b[i]),
            .bin (borrow[i]),
            .d   (diff[i]),
            .bout(borrow[i+1])
        );
    end
endmodule

// File: rtl/seq_restoring_div.sv
// Multi-cycle unsigned restoring divider: one subtract-and-restore step per clock.
// state   | meaning
// IDLE    | waiting for start
// RUN     | iterating, count steps remaining
// DONE    | results valid for one cycle, start may chain a new operation
module seq_restoring_div
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    seq_restoring_div_if.slave bus
);
    localparam int CW = clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   r_reg;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic             borrow;
    logic             accept;
    logic             zero_div;
    logic             last_step;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;
    logic             busy_o;
    logic             done_o;

    assign accept    = bus.start && (state != ST_RUN);
    assign zero_div  = (bus.divisor == '0);
    assign last_step = (state == ST_RUN) && (count == CW'(1));

    assign r_shift = {r_reg[WIDTH-1:0], q_sh[WIDTH-1]};

    full_sub_nb #(
        .N(WIDTH + 1)
    ) u_sub (
        .a         (r_shift),
        .b         ({1'b0, d_reg}),
        .diff      (diff),
        .borrow_out(borrow)
    );

    // No borrow means the divisor fits: keep the difference and shift in a 1.
    assign r_next = borrow ? r_shift : diff;
    assign q_next = {q_sh[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_nxt = zero_div ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (count == CW'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state)
            ST_RUN:  busy_o = 1'b1;
            ST_DONE: done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            q_sh        <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else if (accept) begin
            if (zero_div) begin
                quotient_r  <= '1;
                remainder_r <= bus.dividend;
                dbz_r       <= 1'b1;
            end else begin
                q_sh  <= bus.dividend;
                d_reg <= bus.divisor;
                r_reg <= '0;
                count <= CW'(WIDTH);
            end
        end else if (state == ST_RUN) begin
            r_reg <= r_next;
            q_sh  <= q_next;
            count <= count - CW'(1);
            if (last_step) begin
                quotient_r  <= q_next;
                remainder_r <= r_next[WIDTH-1:0];
                dbz_r       <= 1'b0;
            end
        end
    end

    assign bus.busy        = busy_o;
    assign bus.done        = done_o;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_restoring_div.sv
// Bench for seq_restoring_div at WIDTH=8 and WIDTH=16 against a behavioural model.
module tb_seq_restoring_div;
    localparam int W0 = 8;
    localparam int W1 = 16;

    logic        clk;
    logic        rst_v[2];
    logic        start_v[2];
    logic [31:0] dvd_v[2];
    logic [31:0] dsr_v[2];

    logic        o_busy[2];
    logic        o_done[2];
    logic        o_z[2];
    logic [31:0] o_q[2];
    logic [31:0] o_r[2];

    int n_checks = 0;
    int n_errors = 0;

    seq_restoring_div_if #(.WIDTH(W0)) if8 ();
    seq_restoring_div_if #(.WIDTH(W1)) if16 ();

    assign if8.start     = start_v[0];
    assign if8.dividend  = dvd_v[0][7:0];
    assign if8.divisor   = dsr_v[0][7:0];
    assign if16.start    = start_v[1];
    assign if16.dividend = dvd_v[1][15:0];
    assign if16.divisor  = dsr_v[1][15:0];

    assign o_busy[0] = if8.busy;
    assign o_done[0] = if8.done;
    assign o_z[0]    = if8.div_by_zero;
    assign o_q[0]    = {24'b0, if8.quotient};
    assign o_r[0]    = {24'b0, if8.remainder};
    assign o_busy[1] = if16.busy;
    assign o_done[1] = if16.done;
    assign o_z[1]    = if16.div_by_zero;
    assign o_q[1]    = {16'b0, if16.quotient};
    assign o_r[1]    = {16'b0, if16.remainder};

    seq_restoring_div #(.WIDTH(W0)) u_dut8 (
        .clk  (clk),
        .rst_n(rst_v[0]),
        .bus  (if8)
    );

    seq_restoring_div #(.WIDTH(W1)) u_dut16 (
        .clk  (clk),
        .rst_n(rst_v[1]),
        .bus  (if16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int wdt(input int k);
        return (k == 0) ? W0 : W1;
    endfunction

    function automatic logic [31:0] msk(input int k);
        return (k == 0) ? 32'h0000_00FF : 32'h0000_FFFF;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s w%0d actual=%0d required=%0d", nm, wdt(k), act, exp);
        end
    endtask

    // Transaction-level model: an accepted operation yields dividend/divisor and
    // dividend%divisor after WIDTH busy cycles, or the zero-divisor result at once.
    int unsigned m_rem[2];
    logic        m_done[2];
    logic        m_z[2];
    logic [31:0] m_q[2];
    logic [31:0] m_r[2];
    logic [31:0] m_pq[2];
    logic [31:0] m_pr[2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_v[k]) begin
                m_rem[k]  = 0;
                m_done[k] = 1'b0;
                m_z[k]    = 1'b0;
                m_q[k]    = 32'd0;
                m_r[k]    = 32'd0;
            end else begin
                m_done[k] = 1'b0;
                if (m_rem[k] != 0) begin
                    m_rem[k]--;
                    if (m_rem[k] == 0) begin
                        m_done[k] = 1'b1;
                        m_q[k]    = m_pq[k];
                        m_r[k]    = m_pr[k];
                        m_z[k]    = 1'b0;
                    end
                end else if (start_v[k]) begin
                    if (dsr_v[k] == 32'd0) begin
                        m_done[k] = 1'b1;
                        m_q[k]    = msk(k);
                        m_r[k]    = dvd_v[k];
                        m_z[k]    = 1'b1;
                    end else begin
                        m_pq[k]  = dvd_v[k] / dsr_v[k];
                        m_pr[k]  = dvd_v[k] % dsr_v[k];
                        m_rem[k] = wdt(k);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_v[k]) begin
                chk("busy", k, 32'(o_busy[k]), 32'(m_rem[k] != 0));
                chk("done", k, 32'(o_done[k]), 32'(m_done[k]));
                chk("quotient", k, o_q[k], m_q[k]);
                chk("remainder", k, o_r[k], m_r[k]);
                chk("div_by_zero", k, 32'(o_z[k]), 32'(m_z[k]));
            end
        end
    end

    task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez,
                         input int elat);
        int n;
        int busy_cnt;
        @(negedge clk);
        start_v[k] = 1'b1;
        dvd_v[k]   = a;
        dsr_v[k]   = b;
        n = 0;
        busy_cnt = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            start_v[k] = 1'b0;
            if (o_busy[k]) busy_cnt++;
            if (o_done[k]) break;
        end
        chk("latency", k, n, elat);
        chk("busy_cycles", k, busy_cnt, (b == 0) ? 0 : wdt(k));
        chk("lit_quotient", k, o_q[k], eq);
        chk("lit_remainder", k, o_r[k], er);
        chk("lit_div_by_zero", k, 32'(o_z[k]), 32'(ez));
        if (b != 0) begin
            chk("identity", k, (o_q[k] * b + o_r[k]) & msk(k), a);
            chk("rem_lt_div", k, 32'(o_r[k] < b), 32'd1);
        end
    endtask

    task automatic rand_op(input int k);
        int n;
        logic [31:0] a;
        logic [31:0] b;
        int sel;
        sel = $urandom_range(0, 7);
        b = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) : ($urandom & msk(k));
        a = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 20)) : ($urandom & msk(k));
        @(negedge clk);
        start_v[k] = 1'b1;
        dvd_v[k]   = a;
        dsr_v[k]   = b;
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (o_done[k]) begin
                start_v[k] = 1'b0;
                break;
            end
            // Stray starts while busy must be ignored.
            start_v[k] = ($urandom_range(0, 7) == 0);
            if (start_v[k]) begin
                dvd_v[k] = $urandom & msk(k);
                dsr_v[k] = $urandom & msk(k);
            end
        end
        chk("rand_done_seen", k, 32'(o_done[k]), 32'd1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    initial begin
        int n;
        int m;
        for (int k = 0; k < 2; k++) begin
            rst_v[k]   = 1'b0;
            start_v[k] = 1'b0;
            dvd_v[k]   = 32'd0;
            dsr_v[k]   = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy", k, 32'(o_busy[k]), 32'd0);
            chk("rst_done", k, 32'(o_done[k]), 32'd0);
            chk("rst_quotient", k, o_q[k], 32'd0);
            chk("rst_remainder", k, o_r[k], 32'd0);
            chk("rst_div_by_zero", k, 32'(o_z[k]), 32'd0);
        end
        rst_v[0] = 1'b1;
        rst_v[1] = 1'b1;
        repeat (2) @(negedge clk);

        do_op(0, 100, 7, 14, 2, 1'b0, 9);
        do_op(0, 255, 1, 255, 0, 1'b0, 9);
        do_op(0, 5, 9, 0, 5, 1'b0, 9);
        do_op(0, 0, 3, 0, 0, 1'b0, 9);
        do_op(0, 255, 255, 1, 0, 1'b0, 9);
        do_op(0, 42, 0, 32'hFF, 42, 1'b1, 1);
        do_op(0, 20, 4, 5, 0, 1'b0, 9);

        // Ignored start mid-run, then start held through DONE for a back-to-back op.
        @(negedge clk);
        start_v[0] = 1'b1;
        dvd_v[0]   = 100;
        dsr_v[0]   = 7;
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (o_done[0]) break;
            start_v[0] = (n == 4) || (n >= 7);
            if (start_v[0]) begin
                dvd_v[0] = 9;
                dsr_v[0] = 3;
            end
        end
        chk("ignored_latency", 0, n, 9);
        chk("ignored_quotient", 0, o_q[0], 14);
        chk("ignored_remainder", 0, o_r[0], 2);
        chk("b2b_start_high", 0, 32'(start_v[0]), 32'd1);
        m = 0;
        while (m < 60) begin
            @(negedge clk);
            m++;
            start_v[0] = 1'b0;
            if (o_done[0]) break;
        end
        chk("b2b_latency", 0, m, 9);
        chk("b2b_quotient", 0, o_q[0], 3);
        chk("b2b_remainder", 0, o_r[0], 0);

        // Asynchronous reset between edges while RUN.
        @(negedge clk);
        start_v[0] = 1'b1;
        dvd_v[0]   = 200;
        dsr_v[0]   = 3;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #3;
        rst_v[0] = 1'b0;
        #1;
        chk("arst_busy", 0, 32'(o_busy[0]), 32'd0);
        chk("arst_done", 0, 32'(o_done[0]), 32'd0);
        chk("arst_quotient", 0, o_q[0], 32'd0);
        chk("arst_remainder", 0, o_r[0], 32'd0);
        chk("arst_div_by_zero", 0, 32'(o_z[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_v[0] = 1'b1;
        do_op(0, 50, 6, 8, 2, 1'b0, 9);

        do_op(1, 65535, 255, 257, 0, 1'b0, 17);
        do_op(1, 1234, 0, 32'hFFFF, 1234, 1'b1, 1);
        for (int i = 0; i < 1000; i++) begin
            rand_op(1);
        end
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seq_restoring_div.md
Name: seq_restoring_div

Overview:
- Parametrised, multi-cycle, unsigned restoring divider.
- Generalises the fixed 4-bit ripple subtractor into a WIDTH-bit subtract-and-restore datapath, iterated once per clock.
- Adds a start/busy/done handshake and divide-by-zero detection.
- Sits behind the project's division front-end; one operation in flight at a time.

Parameters:
- WIDTH, 8: operand width in bits for dividend, divisor, quotient and remainder; legal values 2..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled at rising edge only when not busy.
- dividend  input  WIDTH  unsigned dividend; sampled with an accepted start.
- divisor  input  WIDTH  unsigned divisor; sampled with an accepted start.
- busy  output  1  high while an iteration is in progress.
- done  output  1  single-cycle pulse: results valid.
- quotient  output  WIDTH  registered quotient; held until the next accepted start completes.
- remainder  output  WIDTH  registered remainder; held likewise.
- div_by_zero  output  1  set with done when divisor was 0; held with the results.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low; assertion takes effect immediately, independent of clk.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0, div_by_zero = 0
  - quotient = 0, remainder = 0
  - internal counter, partial remainder and shift register = 0
- States: IDLE, RUN, DONE. Encoding is defined in the shared package.
- Start acceptance: start is accepted in IDLE or DONE. It is ignored in RUN, with no effect on an operation in flight.
- Normal operation, divisor != 0:
  - Accepted at edge t0: latch dividend into shift register Q, divisor into D, clear partial remainder R (WIDTH+1 bits), load count = WIDTH, go to RUN. busy = 1 from after t0.
  - Each RUN edge: R' = {R[WIDTH-1:0], Q[WIDTH-1]}; diff = R' - {1'b0, D} via the subtractor.
    - If borrow_out = 0: R = diff, Q = {Q[WIDTH-2:0], 1}.
    - Otherwise: R = R', Q = {Q[WIDTH-2:0], 0}.
    - Then count decrements.
  - At edge tWIDTH (the last step): quotient = final Q, remainder = final R[WIDTH-1:0], div_by_zero = 0, state = DONE.
  - In the cycle after tWIDTH: busy = 0, done = 1.
  - Latency: start edge to done high is WIDTH+1 edges. busy is high for exactly WIDTH cycles.
- Divide by zero (divisor == 0 at acceptance):
  - No RUN cycles; go directly to DONE at t0.
  - quotient = all ones, remainder = dividend, div_by_zero = 1.
  - done is high in the cycle after t0; busy never rises.
- DONE lasts one cycle.
  - If start is high at that edge, the new operation is accepted (back-to-back) and done falls.
  - Otherwise the state returns to IDLE and done falls.
- Outputs quotient, remainder and div_by_zero change only on DONE entry, never mid-operation.
- Reset mid-operation: all outputs and state return to reset values immediately; the pending result is discarded. The first edge after deassertion behaves as IDLE.
- Arithmetic:
  - All operands are unsigned.
  - The subtractor is WIDTH+1 bits wide, so R' never overflows.
  - Results satisfy dividend = quotient*divisor + remainder and remainder < divisor whenever divisor != 0.

Decomposition:
- Shared package div_pkg:
  - state encoding constants ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2
  - counter width function clog2(WIDTH+1)
- Sub-module full_sub_nb:
  - Purely combinational, parameter N (instantiated with N = WIDTH+1).
  - A generate chain of the existing one-bit full_sub cell; borrow-in = 0.
  - Outputs diff[N-1:0] and borrow_out.
- The divider owns the FSM, counter and shift registers only.

Test Plan:
- WIDTH=8, dividend=100, divisor=7, start one cycle -> busy high 8 cycles; done pulse on 9th edge after start; quotient=14, remainder=2, div_by_zero=0.
- WIDTH=8, cases 255/1 -> q=255 r=0; 5/9 -> q=0 r=5; 0/3 -> q=0 r=0; 255/255 -> q=1 r=0, each checked against the identity.
- WIDTH=8, dividend=42, divisor=0 -> done one edge after start, busy never high, quotient=8'hFF, remainder=42, div_by_zero=1. A following 20/4 clears div_by_zero with q=5 r=0.
- Robustness, WIDTH=8:
  - 100/7 in flight; pulse start with 9/3 at cycle 4 -> ignored, result still 14/2.
  - Then start held high through the DONE cycle with 9/3 -> accepted back-to-back; q=3 r=0 after 9 more edges.
  - Assert rst_n low mid-RUN, asynchronously between edges -> busy, done, quotient, remainder drop to 0 immediately; a new 50/6 after release gives q=8 r=2.
- WIDTH=16, 65535/255 -> q=257 r=0 with done at 17th edge. Then 1000 random operand pairs, including divisor=0, checked against a reference model.
